nv_nvdla_dma_wr_rsp: RTL and testbench

NV_NVDLA_DMA_WR_RSP -- requirements
Module: NV_NVDLA_DMA_wr_rsp

---
 rtl/nv_nvdla_dma_wr_rsp.sv | 110 +++++++++++
 tb/tb_nv_nvdla_dma_wr_rsp.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_dma_wr_rsp.sv
// DMA write-response engine: turns a cmd packet plus its data beats into 32-byte memory writes.
// Optional beat statistics counter is enabled by defining NVDLA_DMA_WR_RSP_STATS_EN.
module nv_nvdla_dma_wr_rsp (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic           dma_wr_req_vld,
  output logic           dma_wr_req_rdy,
  input  logic [257:0]   dma_wr_req_pd,
  output logic           mem_wr_vld,
  input  logic           mem_wr_rdy,
  output logic [63:0]    mem_wr_addr,
  output logic [255:0]   mem_wr_data,
  output logic [1:0]     mem_wr_be,
  output logic           dma_wr_rsp_complete,
  output logic           proto_err
`ifdef NVDLA_DMA_WR_RSP_STATS_EN
  ,output logic [31:0]   dma_wr_rsp_beat_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, DRAIN, ACK} state_t;

  state_t       state;
  state_t       next_state;
  logic [63:0]  cmd_addr;
  logic [13:0]  beat_total;
  logic [13:0]  beat_idx;
  logic         need_ack;
  logic         req_acc;
  logic         pkt_is_data;
  logic         mem_acc;
  logic         last_beat;

  assign req_acc     = dma_wr_req_vld & dma_wr_req_rdy;
  assign pkt_is_data = dma_wr_req_pd[257];
  assign mem_acc     = mem_wr_vld & mem_wr_rdy;
  assign last_beat   = ((beat_idx + 14'd1) == beat_total);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (req_acc && !pkt_is_data) next_state = DATA;
      DATA:  if (req_acc && pkt_is_data && last_beat) next_state = DRAIN;
      DRAIN: if (mem_acc) next_state = need_ack ? ACK : IDLE;
      ACK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single output register stage: DATA accepts a new beat whenever that register is free or draining.
  always_comb begin
    dma_wr_req_rdy      = 1'b0;
    dma_wr_rsp_complete = 1'b0;
    unique case (state)
      IDLE:  dma_wr_req_rdy = 1'b1;
      DATA:  dma_wr_req_rdy = !mem_wr_vld || mem_wr_rdy;
      DRAIN: dma_wr_req_rdy = 1'b0;
      ACK:   dma_wr_rsp_complete = 1'b1;
      default: dma_wr_req_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cmd_addr    <= '0;
      beat_total  <= '0;
      beat_idx    <= '0;
      need_ack    <= 1'b0;
      mem_wr_vld  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_be   <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_acc && !pkt_is_data) begin
        cmd_addr   <= {dma_wr_req_pd[63:5], 5'd0};
        beat_total <= {1'b0, dma_wr_req_pd[76:64]} + 14'd1;
        beat_idx   <= '0;
        need_ack   <= dma_wr_req_pd[77];
      end
      if (state == DATA && req_acc && pkt_is_data) begin
        mem_wr_vld  <= 1'b1;
        mem_wr_addr <= cmd_addr + {45'd0, beat_idx, 5'd0};
        mem_wr_data <= dma_wr_req_pd[255:0];
        mem_wr_be   <= {dma_wr_req_pd[256], 1'b1};
        beat_idx    <= beat_idx + 14'd1;
      end else if (mem_acc) begin
        mem_wr_vld <= 1'b0;
      end
      // Wrong packet type for the current phase is dropped but remembered until reset.
      if (req_acc && ((state == IDLE && pkt_is_data) || (state == DATA && !pkt_is_data)))
        proto_err <= 1'b1;
    end
  end

`ifdef NVDLA_DMA_WR_RSP_STATS_EN
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst)
      dma_wr_rsp_beat_cnt <= '0;
    else if (mem_acc && dma_wr_rsp_beat_cnt != 32'hFFFF_FFFF)
      dma_wr_rsp_beat_cnt <= dma_wr_rsp_beat_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_dma_wr_rsp.sv
// Directed self-checking bench for nv_nvdla_dma_wr_rsp; memory writes and ack pulses are
// captured by a negedge monitor and compared against hand-computed expectations.
module tb_nv_nvdla_dma_wr_rsp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_vld = 1'b0;
  logic         dma_wr_req_rdy;
  logic [257:0] req_pd = '0;
  logic         mem_wr_vld;
  logic         mem_rdy = 1'b0;
  logic [63:0]  mem_wr_addr;
  logic [255:0] mem_wr_data;
  logic [1:0]   mem_wr_be;
  logic         complete;
  logic         proto_err;
`ifdef NVDLA_DMA_WR_RSP_STATS_EN
  logic [31:0]  beat_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cpl_n = 0;
  int cpl_cyc = 0;
  logic [63:0]  wq_addr[$];
  logic [255:0] wq_data[$];
  logic [1:0]   wq_be[$];
  int           wq_cyc[$];

  nv_nvdla_dma_wr_rsp dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .dma_wr_req_vld(req_vld),
    .dma_wr_req_rdy(dma_wr_req_rdy),
    .dma_wr_req_pd(req_pd),
    .mem_wr_vld(mem_wr_vld),
    .mem_wr_rdy(mem_rdy),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be),
    .dma_wr_rsp_complete(complete),
    .proto_err(proto_err)
`ifdef NVDLA_DMA_WR_RSP_STATS_EN
    , .dma_wr_rsp_beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after posedge, so negedge values are what the next edge will see.
  always @(negedge clk) begin
    if (!rst && mem_wr_vld && mem_rdy) begin
      wq_addr.push_back(mem_wr_addr);
      wq_data.push_back(mem_wr_data);
      wq_be.push_back(mem_wr_be);
      wq_cyc.push_back(cyc);
    end
    if (complete) begin
      cpl_n   = cpl_n + 1;
      cpl_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [257:0] cmd_pd(input logic [63:0] a, input logic [12:0] sz, input logic ack);
    return {1'b0, 179'd0, ack, sz, a};
  endfunction

  function automatic logic [257:0] data_pd(input logic mask_hi, input logic [255:0] d);
    return {1'b1, mask_hi, d};
  endfunction

  function automatic logic [255:0] beat_data(input int k);
    return {8{32'hD000_0000 | 32'(k)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [257:0] pd, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    req_vld = 1'b1;
    req_pd = pd;
    #1;
    while (!dma_wr_req_rdy && n < 64) begin
      tick();
      n++;
    end
    if (!dma_wr_req_rdy) to = 1'b1;
    else tick();
    req_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (mem_wr_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_vld: got %0b want 0", mem_wr_vld); end
    checks++; if (dma_wr_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_rdy: got %0b want 1", dma_wr_req_rdy); end
    checks++; if (complete !== 1'b0) begin errors++; $display("[TB] FAIL rst_cpl: got %0b want 0", complete); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %0b want 0", proto_err); end
    checks++; if (mem_wr_addr !== 64'd0) begin errors++; $display("[TB] FAIL rst_addr: got %h want 0", mem_wr_addr); end
    checks++; if (mem_wr_data !== 256'd0) begin errors++; $display("[TB] FAIL rst_data: got %h want 0", mem_wr_data); end
    checks++; if (mem_wr_be !== 2'b00) begin errors++; $display("[TB] FAIL rst_be: got %b want 00", mem_wr_be); end
  endtask

`ifdef NVDLA_DMA_WR_RSP_STATS_EN
  task automatic test_stats();
    bit to, any_to;
    any_to = 0;
    do_reset();
    mem_rdy = 1'b1;
    send(cmd_pd(64'h0, 13'd7, 1'b0), to); any_to |= to;
    for (int k = 0; k < 8; k++) begin send(data_pd(1'b1, beat_data(k)), to); any_to |= to; end
    repeat (6) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL stats_send: got timeout want accept"); end
    checks++; if (beat_cnt !== 32'd8) begin errors++; $display("[TB] FAIL stats_cnt: got %0d want 8", beat_cnt); end
  endtask
`endif

  task automatic test_ack_burst();
    bit to, any_to;
    int s, c0, acc_cyc;
    any_to = 0; s = wq_addr.size(); c0 = cpl_n;
    mem_rdy = 1'b1;
    send(cmd_pd(64'h1000, 13'd2, 1'b1), to); any_to |= to;
    send(data_pd(1'b1, beat_data(0)), to); any_to |= to;
    acc_cyc = cyc;
    for (int k = 1; k < 3; k++) begin send(data_pd(1'b1, beat_data(k)), to); any_to |= to; end
    repeat (6) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL burst_send: got timeout want accept"); end
    checks++; if (wq_addr.size() - s != 3) begin errors++; $display("[TB] FAIL burst_count: got %0d want 3", wq_addr.size() - s); end
    if (wq_addr.size() - s >= 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (wq_addr[s+k] !== 64'h1000 + 64'(32 * k)) begin errors++; $display("[TB] FAIL burst_addr%0d: got %h want %h", k, wq_addr[s+k], 64'h1000 + 64'(32 * k)); end
        checks++; if (wq_data[s+k] !== beat_data(k)) begin errors++; $display("[TB] FAIL burst_data%0d: got %h want %h", k, wq_data[s+k], beat_data(k)); end
        checks++; if (wq_be[s+k] !== 2'b11) begin errors++; $display("[TB] FAIL burst_be%0d: got %b want 11", k, wq_be[s+k]); end
      end
      checks++; if (wq_cyc[s] != acc_cyc) begin errors++; $display("[TB] FAIL burst_latency: got cycle %0d want %0d", wq_cyc[s], acc_cyc); end
      checks++; if (wq_cyc[s+2] != wq_cyc[s] + 2) begin errors++; $display("[TB] FAIL burst_bubble: got span %0d want 2", wq_cyc[s+2] - wq_cyc[s]); end
      checks++; if (cpl_cyc != wq_cyc[s+2] + 1) begin errors++; $display("[TB] FAIL burst_cpl_time: got %0d want %0d", cpl_cyc, wq_cyc[s+2] + 1); end
    end
    checks++; if (cpl_n - c0 != 1) begin errors++; $display("[TB] FAIL burst_cpl_n: got %0d want 1", cpl_n - c0); end
  endtask

  task automatic test_no_ack();
    bit to, any_to;
    int s, c0;
    any_to = 0; s = wq_addr.size(); c0 = cpl_n;
    send(cmd_pd(64'h2007, 13'd0, 1'b0), to); any_to |= to;
    send(data_pd(1'b0, beat_data(20)), to); any_to |= to;
    repeat (5) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL noack_send: got timeout want accept"); end
    checks++; if (wq_addr.size() - s != 1) begin errors++; $display("[TB] FAIL noack_count: got %0d want 1", wq_addr.size() - s); end
    if (wq_addr.size() - s >= 1) begin
      checks++; if (wq_addr[s] !== 64'h2000) begin errors++; $display("[TB] FAIL noack_addr: got %h want 2000", wq_addr[s]); end
      checks++; if (wq_be[s] !== 2'b01) begin errors++; $display("[TB] FAIL noack_be: got %b want 01", wq_be[s]); end
      checks++; if (wq_data[s] !== beat_data(20)) begin errors++; $display("[TB] FAIL noack_data: got %h want %h", wq_data[s], beat_data(20)); end
    end
    checks++; if (cpl_n != c0) begin errors++; $display("[TB] FAIL noack_cpl: got %0d want 0", cpl_n - c0); end
    checks++; if (dma_wr_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL noack_idle_rdy: got %0b want 1", dma_wr_req_rdy); end
  endtask

  task automatic test_backpressure();
    bit to, any_to;
    int s, c0;
    any_to = 0; s = wq_addr.size(); c0 = cpl_n;
    mem_rdy = 1'b0;
    send(cmd_pd(64'h3000, 13'd3, 1'b1), to); any_to |= to;
    send(data_pd(1'b1, beat_data(10)), to); any_to |= to;
    req_vld = 1'b1;
    req_pd = data_pd(1'b1, beat_data(11));
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_wr_vld !== 1'b1) begin errors++; $display("[TB] FAIL stall_vld%0d: got %0b want 1", i, mem_wr_vld); end
      checks++; if (mem_wr_addr !== 64'h3000) begin errors++; $display("[TB] FAIL stall_addr%0d: got %h want 3000", i, mem_wr_addr); end
      checks++; if (mem_wr_data !== beat_data(10)) begin errors++; $display("[TB] FAIL stall_data%0d: got %h want %h", i, mem_wr_data, beat_data(10)); end
      checks++; if (dma_wr_req_rdy !== 1'b0) begin errors++; $display("[TB] FAIL stall_rdy%0d: got %0b want 0", i, dma_wr_req_rdy); end
      tick();
    end
    mem_rdy = 1'b1;
    for (int k = 11; k < 14; k++) begin send(data_pd(1'b1, beat_data(k)), to); any_to |= to; end
    repeat (6) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL bp_send: got timeout want accept"); end
    checks++; if (wq_addr.size() - s != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d want 4", wq_addr.size() - s); end
    if (wq_addr.size() - s >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (wq_addr[s+k] !== 64'h3000 + 64'(32 * k)) begin errors++; $display("[TB] FAIL bp_addr%0d: got %h want %h", k, wq_addr[s+k], 64'h3000 + 64'(32 * k)); end
        checks++; if (wq_data[s+k] !== beat_data(10 + k)) begin errors++; $display("[TB] FAIL bp_data%0d: got %h want %h", k, wq_data[s+k], beat_data(10 + k)); end
      end
    end
    checks++; if (cpl_n - c0 != 1) begin errors++; $display("[TB] FAIL bp_cpl: got %0d want 1", cpl_n - c0); end
  endtask

  task automatic test_addr_wrap();
    bit to, any_to;
    int s;
    any_to = 0; s = wq_addr.size();
    send(cmd_pd(64'hFFFF_FFFF_FFFF_FFF3, 13'd1, 1'b0), to); any_to |= to;
    for (int k = 0; k < 2; k++) begin send(data_pd(1'b0, beat_data(30 + k)), to); any_to |= to; end
    repeat (5) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL wrap_send: got timeout want accept"); end
    checks++; if (wq_addr.size() - s != 2) begin errors++; $display("[TB] FAIL wrap_count: got %0d want 2", wq_addr.size() - s); end
    if (wq_addr.size() - s >= 2) begin
      checks++; if (wq_addr[s] !== 64'hFFFF_FFFF_FFFF_FFE0) begin errors++; $display("[TB] FAIL wrap_addr0: got %h want ffffffffffffffe0", wq_addr[s]); end
      checks++; if (wq_addr[s+1] !== 64'h0) begin errors++; $display("[TB] FAIL wrap_addr1: got %h want 0", wq_addr[s+1]); end
    end
  endtask

  task automatic test_max_burst();
    bit to, any_to;
    int s, c0;
    any_to = 0; s = wq_addr.size(); c0 = cpl_n;
    send(cmd_pd(64'h0, 13'h1FFF, 1'b1), to); any_to |= to;
    for (int k = 0; k < 8192; k++) begin send(data_pd(1'b1, beat_data(k)), to); any_to |= to; end
    repeat (6) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL max_send: got timeout want accept"); end
    checks++; if (wq_addr.size() - s != 8192) begin errors++; $display("[TB] FAIL max_count: got %0d want 8192", wq_addr.size() - s); end
    if (wq_addr.size() - s >= 8192) begin
      checks++; if (wq_addr[s+8191] !== 64'h3FFE0) begin errors++; $display("[TB] FAIL max_last_addr: got %h want 3ffe0", wq_addr[s+8191]); end
      checks++; if (wq_data[s+8191] !== beat_data(8191)) begin errors++; $display("[TB] FAIL max_last_data: got %h want %h", wq_data[s+8191], beat_data(8191)); end
    end
    checks++; if (cpl_n - c0 != 1) begin errors++; $display("[TB] FAIL max_cpl: got %0d want 1", cpl_n - c0); end
    checks++; if (dma_wr_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL max_idle_rdy: got %0b want 1", dma_wr_req_rdy); end
  endtask

  task automatic test_proto_err_idle();
    bit to;
    int s;
    s = wq_addr.size();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL perr_pre: got %0b want 0", proto_err); end
    send(data_pd(1'b1, beat_data(40)), to);
    repeat (4) tick();
    checks++; if (to) begin errors++; $display("[TB] FAIL perr_send: got timeout want accept"); end
    checks++; if (wq_addr.size() != s) begin errors++; $display("[TB] FAIL perr_write: got %0d want 0", wq_addr.size() - s); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL perr_flag: got %0b want 1", proto_err); end
    checks++; if (dma_wr_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL perr_rdy: got %0b want 1", dma_wr_req_rdy); end
  endtask

  task automatic test_cmd_in_data();
    bit to, any_to;
    int s, c0;
    any_to = 0; s = wq_addr.size(); c0 = cpl_n;
    send(cmd_pd(64'h5000, 13'd1, 1'b1), to); any_to |= to;
    send(data_pd(1'b1, beat_data(50)), to); any_to |= to;
    send(cmd_pd(64'h9000, 13'd0, 1'b0), to); any_to |= to;
    send(data_pd(1'b1, beat_data(51)), to); any_to |= to;
    repeat (6) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL cid_send: got timeout want accept"); end
    checks++; if (wq_addr.size() - s != 2) begin errors++; $display("[TB] FAIL cid_count: got %0d want 2", wq_addr.size() - s); end
    if (wq_addr.size() - s >= 2) begin
      checks++; if (wq_addr[s+1] !== 64'h5020) begin errors++; $display("[TB] FAIL cid_addr1: got %h want 5020", wq_addr[s+1]); end
      checks++; if (wq_data[s+1] !== beat_data(51)) begin errors++; $display("[TB] FAIL cid_data1: got %h want %h", wq_data[s+1], beat_data(51)); end
    end
    checks++; if (cpl_n - c0 != 1) begin errors++; $display("[TB] FAIL cid_cpl: got %0d want 1", cpl_n - c0); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL cid_sticky: got %0b want 1", proto_err); end
  endtask

  task automatic test_reset_mid_burst();
    bit to, any_to;
    int s, c0;
    any_to = 0; c0 = cpl_n;
    mem_rdy = 1'b1;
    send(cmd_pd(64'h6000, 13'd3, 1'b1), to); any_to |= to;
    send(data_pd(1'b1, beat_data(60)), to); any_to |= to;
    send(data_pd(1'b1, beat_data(61)), to); any_to |= to;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (mem_wr_vld !== 1'b0) begin errors++; $display("[TB] FAIL rmb_vld: got %0b want 0", mem_wr_vld); end
    checks++; if (dma_wr_req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rmb_rdy: got %0b want 1", dma_wr_req_rdy); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL rmb_err_clear: got %0b want 0", proto_err); end
    repeat (4) tick();
    checks++; if (cpl_n != c0) begin errors++; $display("[TB] FAIL rmb_cpl: got %0d want 0", cpl_n - c0); end
    s = wq_addr.size();
    send(cmd_pd(64'h7000, 13'd0, 1'b1), to); any_to |= to;
    send(data_pd(1'b1, beat_data(70)), to); any_to |= to;
    repeat (5) tick();
    checks++; if (any_to) begin errors++; $display("[TB] FAIL rmb_send: got timeout want accept"); end
    checks++; if (wq_addr.size() - s != 1) begin errors++; $display("[TB] FAIL rmb_next_count: got %0d want 1", wq_addr.size() - s); end
    if (wq_addr.size() - s >= 1) begin
      checks++; if (wq_addr[s] !== 64'h7000) begin errors++; $display("[TB] FAIL rmb_next_addr: got %h want 7000", wq_addr[s]); end
    end
    checks++; if (cpl_n - c0 != 1) begin errors++; $display("[TB] FAIL rmb_next_cpl: got %0d want 1", cpl_n - c0); end
  endtask

  initial begin
    test_reset();
`ifdef NVDLA_DMA_WR_RSP_STATS_EN
    test_stats();
`endif
    test_ack_burst();
    test_no_ack();
    test_backpressure();
    test_addr_wrap();
    test_max_burst();
    test_proto_err_idle();
    test_cmd_in_data();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
